pong_score_ctrl: RTL and testbench
==================================

Name: pong_score_ctrl

Overview:
- Game-level consumer of the ball position and paddle positions.
- Detects misses at either goal column, keeps both players' scores and declares a winner.
- Drives the game-active signal that starts and recentres the ball controller.
- Sits between the ball controller, the two paddle controllers and the score/text display logic.

Parameters:
c_GAME_WIDTH, 40, playfield width in game units
c_GAME_HEIGHT, 30, playfield height in game units
c_PADDLE_HEIGHT, 6, paddle length in game units
c_PADDLE_COL_P1, 0, column of player-1 paddle (left goal)
c_PADDLE_COL_P2, 39, column of player-2 paddle (right goal); must equal c_GAME_WIDTH-1
c_SCORE_LIMIT, 9, points needed to win; 1..15
c_SERVE_DELAY, 50000000, cycles between a point and the auto-serve (used only with the optional feature)

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  synchronous active-low reset
i_Start  in  1  one-cycle start/serve request
i_Ball_X  in  $clog2(c_GAME_WIDTH)  current ball column
i_Ball_Y  in  $clog2(c_GAME_HEIGHT)  current ball row
i_Paddle_Y_P1  in  $clog2(c_GAME_HEIGHT)  top row of P1 paddle
i_Paddle_Y_P2  in  $clog2(c_GAME_HEIGHT)  top row of P2 paddle
o_Game_Active  out  1  high while the ball is in play
o_P1_Score  out  4  player-1 score
o_P2_Score  out  4  player-2 score
o_Point  out  1  one-cycle pulse on any scored point
o_Winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- Single clock i_Clk. Reset is synchronous and active-low (i_Rst_L); all state is sampled on the rising edge of i_Clk.
- Reset values: state IDLE, o_Game_Active=0, both scores 0, o_Point=0, o_Winner=00, serve counter 0.
- Reset asserted mid-game aborts immediately to the reset values on the next edge.
- Paddle hit test for each paddle: hit when i_Ball_Y >= Paddle_Y and i_Ball_Y < Paddle_Y + c_PADDLE_HEIGHT.
  - Compute the sum one bit wider than the row width, so a paddle near the bottom does not wrap.
- State IDLE:
  - o_Game_Active=0.
  - i_Start moves to RUNNING.
  - Ball controller recentres while in IDLE.
- State RUNNING:
  - o_Game_Active=1.
  - i_Ball_X==c_PADDLE_COL_P1 and no P1 hit -> P2_POINT.
  - Else i_Ball_X==c_PADDLE_COL_P2 and no P2 hit -> P1_POINT.
  - P1-goal check has priority if both are true.
  - i_Start is ignored.
- States P1_POINT / P2_POINT (exactly one cycle each):
  - o_Game_Active=0; the scorer's score increments by 1.
  - o_Point=1 registered, so it is visible in the same cycle as the new score.
  - New score == c_SCORE_LIMIT -> GAME_OVER, with o_Winner set to 01 or 10 in the same cycle as the final score.
  - Otherwise -> IDLE.
- State GAME_OVER:
  - o_Game_Active=0; scores and o_Winner are held.
  - i_Start clears both scores and o_Winner and moves to RUNNING on the next edge.
- Scores never exceed c_SCORE_LIMIT and never wrap.
- Latency: ball arriving at a goal column with a miss -> o_Game_Active low 1 cycle later, then o_Point pulse the cycle after that.
- Because the FSM leaves RUNNING, a ball resting at a goal column for many cycles scores exactly once.
- o_Point is high only in the POINT states; it is never high two consecutive cycles.

Optional Feature:
- Macro PONG_AUTO_SERVE_EN.
- Defined:
  - From IDLE, but only when IDLE was entered from a POINT state, a counter runs 0..c_SERVE_DELAY-1.
  - At terminal count the block enters RUNNING without i_Start.
  - i_Start during the countdown serves immediately and clears the counter.
  - The counter clears on every IDLE entry and on reset.
  - IDLE after reset still requires i_Start.
- Not defined: no counter logic is present; every serve requires i_Start.

Test Plan:
- Reset low 3 cycles mid-RUNNING with scores 3/2 -> scores 0/0, o_Game_Active=0, o_Winner=00 on the first edge with i_Rst_L low.
- i_Start, then ball X=0, Y=10, P1 paddle Y=12 -> one cycle later o_Game_Active=0; next cycle o_P2_Score=1 with o_Point=1 for exactly 1 cycle. Hold ball there 100 cycles -> no further increments.
- Ball X=39, Y=29, P2 paddle Y=24 (covers rows 24-29) -> hit, no point, o_Game_Active stays 1. Repeat with P2 paddle Y=23 -> o_P1_Score increments.
- Drive P1 to 9 points with c_SCORE_LIMIT=9 -> o_Winner=01 in the same cycle as score 9. i_Start in GAME_OVER -> scores 0/0, RUNNING.
- With PONG_AUTO_SERVE_EN and c_SERVE_DELAY=20: after a point, o_Game_Active returns to 1 exactly 20 cycles after IDLE entry with no i_Start. Without the macro, it stays 0 for 1000 cycles.

Source files
------------

// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: game-level scorer for Pong.
// Watches the ball at both goal columns, tests it against the defending
// paddle, counts points for both players and declares a winner.
// o_Game_Active starts the ball controller and recentres it while low.
//
// Optional build macro: PONG_AUTO_SERVE_EN
//   When defined, the block re-serves on its own c_SERVE_DELAY cycles after
//   returning to IDLE from a point. When undefined, every serve needs i_Start.

module pong_score_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_PADDLE_COL_P1 = 0,
  parameter int c_PADDLE_COL_P2 = 39,
  parameter int c_SCORE_LIMIT   = 9,
  parameter int c_SERVE_DELAY   = 50000000
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_L,
  input  logic                              i_Start,
  input  logic [$clog2(c_GAME_WIDTH)-1:0]   i_Ball_X,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0]  i_Ball_Y,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0]  i_Paddle_Y_P1,
  input  logic [$clog2(c_GAME_HEIGHT)-1:0]  i_Paddle_Y_P2,
  output logic                              o_Game_Active,
  output logic [3:0]                        o_P1_Score,
  output logic [3:0]                        o_P2_Score,
  output logic                              o_Point,
  output logic [1:0]                        o_Winner
);

  localparam int XW = $clog2(c_GAME_WIDTH);
  localparam int YW = $clog2(c_GAME_HEIGHT);

  localparam logic [XW-1:0] COL_P1   = XW'(c_PADDLE_COL_P1);
  localparam logic [XW-1:0] COL_P2   = XW'(c_PADDLE_COL_P2);
  localparam logic [YW:0]   PADDLE_H = (YW+1)'(c_PADDLE_HEIGHT);
  localparam logic [3:0]    LIMIT    = 4'(c_SCORE_LIMIT);

  // An illegal parameter set keeps the block parked in IDLE, which makes the
  // mistake obvious on the first attempt to play instead of scoring garbage.
  localparam bit CFG_OK = (c_PADDLE_COL_P2 == c_GAME_WIDTH - 1) &&
                          (c_SCORE_LIMIT >= 1) && (c_SCORE_LIMIT <= 15) &&
                          (c_SERVE_DELAY >= 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUNNING,
    S_P1_POINT,
    S_P2_POINT,
    S_GAME_OVER
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] p1_score_nxt, p2_score_nxt;
  logic [1:0] winner_nxt;
  logic       point_nxt;
  logic       start_ok;
  logic       serve_due;
  logic [YW:0] p1_bottom, p2_bottom;
  logic        hit_p1, hit_p2;

  // Score increment that can never pass the limit or wrap the 4-bit field.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= LIMIT) return LIMIT;
    else            return v + 4'd1;
  endfunction

  assign start_ok = i_Start && CFG_OK;

  // Paddle spans [top, top+height); the bottom edge is one bit wider so a
  // paddle near the last row does not wrap around to the top.
  always_comb begin
    p1_bottom = {1'b0, i_Paddle_Y_P1} + PADDLE_H;
    p2_bottom = {1'b0, i_Paddle_Y_P2} + PADDLE_H;
    hit_p1 = ({1'b0, i_Ball_Y} >= {1'b0, i_Paddle_Y_P1}) && ({1'b0, i_Ball_Y} < p1_bottom);
    hit_p2 = ({1'b0, i_Ball_Y} >= {1'b0, i_Paddle_Y_P2}) && ({1'b0, i_Ball_Y} < p2_bottom);
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt    = state;
    p1_score_nxt = o_P1_Score;
    p2_score_nxt = o_P2_Score;
    winner_nxt   = o_Winner;
    point_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok || serve_due) state_nxt = S_RUNNING;
      end
      S_RUNNING: begin
        // Left goal wins the tie when both goal tests fire in one cycle.
        if (i_Ball_X == COL_P1 && !hit_p1)      state_nxt = S_P2_POINT;
        else if (i_Ball_X == COL_P2 && !hit_p2) state_nxt = S_P1_POINT;
      end
      S_P1_POINT: begin
        p1_score_nxt = sat_inc(o_P1_Score);
        point_nxt    = 1'b1;
        if (p1_score_nxt == LIMIT) begin
          state_nxt  = S_GAME_OVER;
          winner_nxt = 2'b01;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      S_P2_POINT: begin
        p2_score_nxt = sat_inc(o_P2_Score);
        point_nxt    = 1'b1;
        if (p2_score_nxt == LIMIT) begin
          state_nxt  = S_GAME_OVER;
          winner_nxt = 2'b10;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      S_GAME_OVER: begin
        if (start_ok) begin
          p1_score_nxt = 4'd0;
          p2_score_nxt = 4'd0;
          winner_nxt   = 2'b00;
          state_nxt    = S_RUNNING;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, score and output registers; o_Point lands with the new score.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state         <= S_IDLE;
      o_Game_Active <= 1'b0;
      o_P1_Score    <= 4'd0;
      o_P2_Score    <= 4'd0;
      o_Point       <= 1'b0;
      o_Winner      <= 2'b00;
    end else begin
      state         <= state_nxt;
      o_Game_Active <= (state_nxt == S_RUNNING);
      o_P1_Score    <= p1_score_nxt;
      o_P2_Score    <= p2_score_nxt;
      o_Point       <= point_nxt;
      o_Winner      <= winner_nxt;
    end
  end

`ifdef PONG_AUTO_SERVE_EN
  localparam int CNT_W = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(c_SERVE_DELAY - 1);

  logic [CNT_W-1:0] serve_cnt;
  logic             serve_armed;

  assign serve_due = (state == S_IDLE) && serve_armed && (serve_cnt == CNT_LAST);

  // Serve countdown: armed only on IDLE entry from a point, cleared on any
  // IDLE entry and whenever the ball goes back into play.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      serve_cnt   <= '0;
      serve_armed <= 1'b0;
    end else if (state != S_IDLE && state_nxt == S_IDLE) begin
      serve_cnt   <= '0;
      serve_armed <= (state == S_P1_POINT) || (state == S_P2_POINT);
    end else if (state == S_IDLE && state_nxt != S_IDLE) begin
      serve_cnt   <= '0;
      serve_armed <= 1'b0;
    end else if (state == S_IDLE && serve_armed) begin
      serve_cnt   <= serve_cnt + 1'b1;
    end
  end
`else
  assign serve_due = 1'b0;
`endif

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Bench for pong_score_ctrl: directed game scenarios plus random play,
// every cycle compared against a rule-level model of the game.
module tb_pong_score_ctrl;

  localparam int SERVE = 20;
  localparam int LIMIT = 9;
  localparam int PH    = 6;
`ifdef PONG_AUTO_SERVE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_Start = 1'b0;
  logic [5:0] bx = 6'd20;
  logic [4:0] by = 5'd0;
  logic [4:0] p1y = 5'd0;
  logic [4:0] p2y = 5'd0;
  logic       o_Game_Active;
  logic [3:0] o_P1_Score, o_P2_Score;
  logic       o_Point;
  logic [1:0] o_Winner;

  always #5 i_Clk = ~i_Clk;

  pong_score_ctrl #(.c_SERVE_DELAY(SERVE)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Start(i_Start),
    .i_Ball_X(bx), .i_Ball_Y(by),
    .i_Paddle_Y_P1(p1y), .i_Paddle_Y_P2(p2y),
    .o_Game_Active(o_Game_Active), .o_P1_Score(o_P1_Score),
    .o_P2_Score(o_P2_Score), .o_Point(o_Point), .o_Winner(o_Winner)
  );

  int total = 0;
  int bad   = 0;

  // Game model: who is serving/playing, pending scorer, countdown.
  int m_p1, m_p2, m_win, m_pending, m_cnt;
  bit m_play, m_over, m_armed, m_point;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input int ball_y, input int pad_y);
    return (ball_y >= pad_y) && (ball_y < pad_y + PH);
  endfunction

  task automatic model_step();
    if (!i_Rst_L) begin
      m_p1 = 0; m_p2 = 0; m_win = 0; m_pending = 0; m_cnt = 0;
      m_play = 0; m_over = 0; m_armed = 0; m_point = 0;
    end else begin
      m_point = 0;
      if (m_pending != 0) begin
        if (m_pending == 1) m_p1++; else m_p2++;
        m_point = 1;
        if ((m_pending == 1 ? m_p1 : m_p2) == LIMIT) begin
          m_win = m_pending; m_over = 1;
        end else begin
          m_armed = AUTO; m_cnt = 0;
        end
        m_pending = 0;
      end else if (m_play) begin
        if (int'(bx) == 0 && !hit(int'(by), int'(p1y))) begin
          m_pending = 2; m_play = 0;
        end else if (int'(bx) == 39 && !hit(int'(by), int'(p2y))) begin
          m_pending = 1; m_play = 0;
        end
      end else if (m_over) begin
        if (i_Start) begin
          m_p1 = 0; m_p2 = 0; m_win = 0; m_over = 0; m_play = 1;
        end
      end else begin
        if (i_Start || (m_armed && m_cnt == SERVE - 1)) begin
          m_play = 1; m_armed = 0; m_cnt = 0;
        end else if (m_armed) begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
    model_step();
    check_eq("active", 8'(o_Game_Active), 8'(m_play));
    check_eq("p1_score", 8'(o_P1_Score), 8'(m_p1));
    check_eq("p2_score", 8'(o_P2_Score), 8'(m_p2));
    check_eq("point", 8'(o_Point), 8'(m_point));
    check_eq("winner", 8'(o_Winner), 8'(m_win));
  endtask

  // Serve, let the ball travel, then miss at the loser's goal.
  task automatic point_for(input int who);
    i_Start = 1'b1; bx = 6'd20; step();
    i_Start = 1'b0; step();
    if (who == 1) begin bx = 6'd39; by = 5'd29; p2y = 5'd23; end
    else          begin bx = 6'd0;  by = 5'd10; p1y = 5'd12; end
    repeat (3) step();
    bx = 6'd20; step();
  endtask

  initial begin
    // Reset state
    i_Rst_L = 1'b0;
    repeat (3) step();
    i_Rst_L = 1'b1;
    step();

    // Miss at the left goal, held there for 100 cycles
    i_Start = 1'b1; step();
    i_Start = 1'b0; bx = 6'd20; step();
    bx = 6'd0; by = 5'd10; p1y = 5'd12;
    step();
    step();
    check_eq("miss_p2_score", 8'(o_P2_Score), 8'd1);
    check_eq("miss_point", 8'(o_Point), 8'd1);
    repeat (100) step();
    bx = 6'd20; step();

    // Bottom-row paddle hit, then a one-row-higher paddle that misses
    i_Start = 1'b1; step();
    i_Start = 1'b0;
    bx = 6'd39; by = 5'd29; p2y = 5'd24;
    repeat (5) step();
    check_eq("bottom_hit_active", 8'(o_Game_Active), 8'd1);
    p2y = 5'd23;
    repeat (4) step();
    bx = 6'd20; step();

    // Reach 3/2 then pull reset mid-rally
    i_Rst_L = 1'b0; step(); i_Rst_L = 1'b1; step();
    repeat (3) point_for(1);
    repeat (2) point_for(2);
    i_Start = 1'b1; step(); i_Start = 1'b0; step();
    i_Rst_L = 1'b0;
    step();
    check_eq("rst_mid_p1", 8'(o_P1_Score), 8'd0);
    check_eq("rst_mid_active", 8'(o_Game_Active), 8'd0);
    repeat (2) step();
    i_Rst_L = 1'b1; step();

    // P1 plays to the limit, then restart from GAME_OVER
    repeat (LIMIT) point_for(1);
    check_eq("win_p1", 8'(o_Winner), 8'd1);
    check_eq("win_score", 8'(o_P1_Score), 8'(LIMIT));
    i_Start = 1'b1; step(); i_Start = 1'b0;
    check_eq("restart_p1", 8'(o_P1_Score), 8'd0);
    check_eq("restart_active", 8'(o_Game_Active), 8'd1);
    step();

    // Long idle after a point: auto-serve or stay idle
    i_Rst_L = 1'b0; step(); i_Rst_L = 1'b1; step();
    point_for(2);
    repeat (1000) step();

    // Random play
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)      bx = 6'd0;
      else if (r < 4) bx = 6'd39;
      else            bx = 6'($urandom_range(1, 38));
      by  = 5'($urandom_range(0, 31));
      p1y = 5'($urandom_range(0, 31));
      p2y = 5'($urandom_range(0, 31));
      i_Start = ($urandom_range(0, 15) == 0);
      i_Rst_L = ($urandom_range(0, 199) != 0);
      repeat ($urandom_range(1, 3)) step();
    end
    i_Start = 1'b0; i_Rst_L = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
